pipe_ctrl_unit: RTL and testbench

//  Pipelined successor to the single-cycle control decoder. Decodes the ID-stage opcode

---
 rtl/pipe_ctrl_pkg.sv | 63 ++++++
 rtl/pipe_ctrl_unit_decode.sv | 55 +++++
 rtl/pipe_ctrl_unit.sv | 111 +++++++++++
 tb/tb_pipe_ctrl_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipelined control unit: field widths, opcode
//   values, ALUOp encodings and the per-stage control bundles.
//   ctrl_bundle_t is what the decoder produces. ex_ctrl_t is the part that
//   travels through ID/EX. mem_ctrl_t and wb_ctrl_t are the shrinking subsets
//   carried by EX/MEM and MEM/WB.
package pipe_ctrl_pkg;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_J      = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_BEQ    = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_LW     = 6'd35;
    localparam logic [OPCODE_W-1:0] OP_SW     = 6'd43;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_IMM   = 2'b11;

    typedef struct packed {
        logic               regdst;
        logic               alusrc;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
    } ex_ctrl_t;

    // The jump bit is consumed in ID only, so it sits outside ex_ctrl_t.
    typedef struct packed {
        logic     jump;
        ex_ctrl_t ex;
    } ctrl_bundle_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    function automatic mem_ctrl_t to_mem(input ex_ctrl_t c);
        mem_ctrl_t m;
        m.memread  = c.memread;
        m.memwrite = c.memwrite;
        m.regwrite = c.regwrite;
        m.memtoreg = c.memtoreg;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode
//   Purely combinational opcode decoder.
//   Ports:
//     valid   in  1         instruction in IF/ID is real (0 decodes as NOP)
//     opcode  in  OPCODE_W  ID-stage opcode
//     ctrl    out bundle    decoded control bundle (all zeros for NOP/unknown)
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter logic [OPCODE_W-1:0] IMM_OP = OP_IMM
) (
    input  logic                valid,
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_bundle_t        ctrl
);

    always_comb begin
        ctrl = '0;
        if (valid) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl.ex.regdst   = 1'b1;
                    ctrl.ex.regwrite = 1'b1;
                    ctrl.ex.aluop    = ALUOP_RTYPE;
                end
                OP_LW: begin
                    ctrl.ex.regwrite = 1'b1;
                    ctrl.ex.memread  = 1'b1;
                    ctrl.ex.memtoreg = 1'b1;
                    ctrl.ex.alusrc   = 1'b1;
                    ctrl.ex.aluop    = ALUOP_ADD;
                end
                OP_SW: begin
                    ctrl.ex.memwrite = 1'b1;
                    ctrl.ex.alusrc   = 1'b1;
                    ctrl.ex.aluop    = ALUOP_ADD;
                end
                OP_BEQ: begin
                    ctrl.ex.branch   = 1'b1;
                    ctrl.ex.aluop    = ALUOP_SUB;
                end
                OP_J: begin
                    ctrl.jump        = 1'b1;
                end
                IMM_OP: begin
                    ctrl.ex.aluop    = ALUOP_IMM;
                    ctrl.ex.alusrc   = 1'b1;
                    ctrl.ex.regwrite = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
//   Pipelined control: decodes the ID opcode, carries controls through
//   ID/EX, EX/MEM and MEM/WB, inserts load-use stalls and handles
//   jump / taken-branch flushes.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     id_valid_i, id_opcode_i    ID instruction valid and opcode
//     id_rs_i, id_rt_i, id_rd_i  ID register specifiers
//     ex_br_taken_i              branch in EX resolved taken
//     stall_o                    hold PC and IF/ID
//     flush_ifid_o               clear IF/ID at next edge
//     id_jump_o                  jump taken from ID
//     ex_*                       ID/EX controls and EX destination register
//     mem_read_o, mem_write_o    EX/MEM controls
//     wb_regwrite_o, wb_memtoreg_o  MEM/WB controls
//   Priority in one cycle: taken-branch flush > load-use stall > jump.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int                  OPCODE_W_P = OPCODE_W,
    parameter int                  REG_W_P    = REG_W,
    parameter int                  ALUOP_W_P  = ALUOP_W,
    parameter logic [OPCODE_W-1:0] IMM_OP     = OP_IMM,
    parameter bit                  HAZ_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [OPCODE_W_P-1:0] id_opcode_i,
    input  logic [REG_W_P-1:0]    id_rs_i,
    input  logic [REG_W_P-1:0]    id_rt_i,
    input  logic [REG_W_P-1:0]    id_rd_i,
    input  logic                  ex_br_taken_i,
    output logic                  stall_o,
    output logic                  flush_ifid_o,
    output logic                  id_jump_o,
    output logic                  ex_regdst_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_branch_o,
    output logic [ALUOP_W_P-1:0]  ex_aluop_o,
    output logic [REG_W_P-1:0]    ex_dst_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  wb_regwrite_o,
    output logic                  wb_memtoreg_o
);

    ctrl_bundle_t             id_ctrl;
    ex_ctrl_t                 idex_q;
    logic [REG_W_P-1:0]       idex_dst_q;
    logic [REG_W_P-1:0]       id_dst;
    mem_ctrl_t                exmem_q;
    wb_ctrl_t                 memwb_q;
    logic                     br_flush;
    logic                     load_use;
    logic                     idex_zero;

    ctrl_decode #(.IMM_OP(IMM_OP)) u_decode (
        .valid  (id_valid_i),
        .opcode (id_opcode_i),
        .ctrl   (id_ctrl)
    );

    assign id_dst   = id_ctrl.ex.regdst ? id_rd_i : id_rt_i;
    assign br_flush = idex_q.branch & ex_br_taken_i;

    // rt is compared for every opcode; a spurious stall costs one cycle only.
    assign load_use = HAZ_EN & idex_q.memread & (idex_dst_q != '0)
                    & ((idex_dst_q == id_rs_i) | (idex_dst_q == id_rt_i))
                    & ~br_flush;

    // rst_n gate keeps the combinational jump output quiet during reset.
    assign id_jump_o    = rst_n & id_ctrl.jump & ~load_use & ~br_flush;
    assign stall_o      = load_use;
    assign flush_ifid_o = br_flush | id_jump_o;

    // A jump never reaches EX with live controls; neither does a stalled or
    // flushed instruction.
    assign idex_zero = br_flush | load_use | id_ctrl.jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q     <= '0;
            idex_dst_q <= '0;
            exmem_q    <= '0;
            memwb_q    <= '0;
        end else begin
            if (idex_zero) begin
                idex_q     <= '0;
                idex_dst_q <= '0;
            end else begin
                idex_q     <= id_ctrl.ex;
                idex_dst_q <= id_dst;
            end
            exmem_q          <= to_mem(idex_q);
            memwb_q.regwrite <= exmem_q.regwrite;
            memwb_q.memtoreg <= exmem_q.memtoreg;
        end
    end

    assign ex_regdst_o   = idex_q.regdst;
    assign ex_alusrc_o   = idex_q.alusrc;
    assign ex_branch_o   = idex_q.branch;
    assign ex_aluop_o    = idex_q.aluop;
    assign ex_dst_o      = idex_dst_q;
    assign mem_read_o    = exmem_q.memread;
    assign mem_write_o   = exmem_q.memwrite;
    assign wb_regwrite_o = memwb_q.regwrite;
    assign wb_memtoreg_o = memwb_q.memtoreg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit
//   Directed bench for pipe_ctrl_unit. u_dut has load-use detection enabled,
//   u_noh is the same design with it disabled; both see identical stimulus.
//   Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_pipe_ctrl_unit;

    localparam logic [5:0] R_OP   = 6'd0;
    localparam logic [5:0] J_OP   = 6'd2;
    localparam logic [5:0] BEQ_OP = 6'd4;
    localparam logic [5:0] IMM_OP = 6'd7;
    localparam logic [5:0] LW_OP  = 6'd35;
    localparam logic [5:0] SW_OP  = 6'd43;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       br_taken;

    logic       stall, flush, jump, regdst, alusrc, branch;
    logic [1:0] aluop;
    logic [4:0] dst;
    logic       memr, memw, wbrw, wbm2r;

    logic       stall2, flush2, jump2, regdst2, alusrc2, branch2;
    logic [1:0] aluop2;
    logic [4:0] dst2;
    logic       memr2, memw2, wbrw2, wbm2r2;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    logic [16:0] all_out;
    logic [9:0]  ex_vec;
    assign all_out = {stall, flush, jump, regdst, alusrc, branch, aluop, dst,
                      memr, memw, wbrw, wbm2r};
    assign ex_vec  = {regdst, alusrc, branch, aluop, dst};

    pipe_ctrl_unit #(.HAZ_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_opcode_i(id_opcode),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .ex_br_taken_i(br_taken),
        .stall_o(stall), .flush_ifid_o(flush), .id_jump_o(jump),
        .ex_regdst_o(regdst), .ex_alusrc_o(alusrc), .ex_branch_o(branch),
        .ex_aluop_o(aluop), .ex_dst_o(dst), .mem_read_o(memr), .mem_write_o(memw),
        .wb_regwrite_o(wbrw), .wb_memtoreg_o(wbm2r)
    );

    pipe_ctrl_unit #(.HAZ_EN(1'b0)) u_noh (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_opcode_i(id_opcode),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .ex_br_taken_i(br_taken),
        .stall_o(stall2), .flush_ifid_o(flush2), .id_jump_o(jump2),
        .ex_regdst_o(regdst2), .ex_alusrc_o(alusrc2), .ex_branch_o(branch2),
        .ex_aluop_o(aluop2), .ex_dst_o(dst2), .mem_read_o(memr2), .mem_write_o(memw2),
        .wb_regwrite_o(wbrw2), .wb_memtoreg_o(wbm2r2)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: apply one ID-stage instruction at the falling edge.
    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic br);
        @(negedge clk);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        br_taken  = br;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, R_OP, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        br_taken = 1'b0;

        // 1: reset holds everything at zero while R ops are presented
        drive(1'b1, R_OP, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("rst_hold_a", 32'(all_out), 32'd0);
        drive(1'b1, R_OP, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("rst_hold_b", 32'(all_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release", 32'(all_out), 32'd0);
        nop();
        chk("r_ex_regdst", 32'(regdst), 32'd1);
        chk("r_ex_aluop", 32'(aluop), 32'd2);
        chk("r_ex_dst", 32'(dst), 32'd3);
        nop();
        chk("r_wb_early", 32'(wbrw), 32'd0);
        nop();
        chk("r_wb_regwrite", 32'(wbrw), 32'd1);
        nop();
        chk("nop_wb_clear", 32'(wbrw), 32'd0);

        // 2: load-use hazard on rs
        drive(1'b1, LW_OP, 5'd1, 5'd8, 5'd0, 1'b0);
        drive(1'b1, R_OP, 5'd8, 5'd2, 5'd9, 1'b0);
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_ex_lw_alusrc", 32'(alusrc), 32'd1);
        chk("lu_ex_lw_dst", 32'(dst), 32'd8);
        chk("lu_noh_stall", 32'(stall2), 32'd0);
        drive(1'b1, R_OP, 5'd8, 5'd2, 5'd9, 1'b0);
        chk("lu_stall_once", 32'(stall), 32'd0);
        chk("lu_bubble", 32'(ex_vec), 32'd0);
        chk("lu_mem_read", 32'(memr), 32'd1);
        chk("lu_noh_r_early", 32'(regdst2), 32'd1);
        nop();
        chk("lu_r_late_regdst", 32'(regdst), 32'd1);
        chk("lu_r_late_dst", 32'(dst), 32'd9);
        chk("lu_mem_bubble", 32'(memr), 32'd0);
        chk("lu_wb_memtoreg", 32'(wbm2r), 32'd1);
        repeat (3) nop();

        // 3: LW to $0 never stalls
        drive(1'b1, LW_OP, 5'd1, 5'd0, 5'd0, 1'b0);
        drive(1'b1, R_OP, 5'd0, 5'd0, 5'd9, 1'b0);
        chk("lu_r0_no_stall", 32'(stall), 32'd0);
        nop();
        chk("lu_r0_r_in_ex", 32'(regdst), 32'd1);
        repeat (2) nop();

        // Stall beats jump: J in ID with a hazard on rs waits one cycle
        drive(1'b1, LW_OP, 5'd1, 5'd8, 5'd0, 1'b0);
        drive(1'b1, J_OP, 5'd8, 5'd0, 5'd0, 1'b0);
        chk("lu_j_stall", 32'(stall), 32'd1);
        chk("lu_j_jump_held", 32'(jump), 32'd0);
        chk("lu_j_no_flush", 32'(flush), 32'd0);
        drive(1'b1, J_OP, 5'd8, 5'd0, 5'd0, 1'b0);
        chk("lu_j_jump_go", 32'(jump), 32'd1);
        repeat (3) nop();

        // Scoreboarded stream: {aluop, dst} expected one cycle after issue
        drive(1'b1, R_OP, 5'd1, 5'd2, 5'd3, 1'b0);
        exp_q.push_back({2'b10, 5'd3});
        drive(1'b1, IMM_OP, 5'd1, 5'd4, 5'd6, 1'b0);
        chk("sb_ex", 32'({aluop, dst}), 32'(exp_q.pop_front()));
        exp_q.push_back({2'b11, 5'd4});
        drive(1'b1, SW_OP, 5'd1, 5'd5, 5'd7, 1'b0);
        chk("sb_ex", 32'({aluop, dst}), 32'(exp_q.pop_front()));
        chk("sb_imm_alusrc", 32'(alusrc), 32'd1);
        exp_q.push_back({2'b00, 5'd5});
        drive(1'b1, BEQ_OP, 5'd1, 5'd6, 5'd1, 1'b0);
        chk("sb_ex", 32'({aluop, dst}), 32'(exp_q.pop_front()));
        exp_q.push_back({2'b01, 5'd6});
        nop();
        chk("sb_ex", 32'({aluop, dst}), 32'(exp_q.pop_front()));
        chk("sb_imm_wb", 32'(wbrw), 32'd1);
        repeat (3) nop();

        // 4: taken branch flushes and beats a jump in ID
        drive(1'b1, BEQ_OP, 5'd1, 5'd2, 5'd0, 1'b0);
        drive(1'b1, J_OP, 5'd0, 5'd0, 5'd0, 1'b1);
        chk("br_ex_branch", 32'(branch), 32'd1);
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_jump_suppressed", 32'(jump), 32'd0);
        nop();
        chk("br_bubble", 32'(ex_vec), 32'd0);
        drive(1'b1, BEQ_OP, 5'd1, 5'd2, 5'd0, 1'b0);
        drive(1'b1, R_OP, 5'd1, 5'd2, 5'd5, 1'b0);
        chk("br_not_taken_flush", 32'(flush), 32'd0);
        nop();
        chk("br_not_taken_dst", 32'(dst), 32'd5);
        chk("br_not_taken_regdst", 32'(regdst), 32'd1);
        repeat (3) nop();

        // 5: jump
        drive(1'b1, J_OP, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("j_jump", 32'(jump), 32'd1);
        chk("j_flush", 32'(flush), 32'd1);
        nop();
        chk("j_ex_zero", 32'(ex_vec), 32'd0);
        nop();
        chk("j_mem_write", 32'(memw), 32'd0);
        nop();
        chk("j_wb_regwrite", 32'(wbrw), 32'd0);

        // 6: asynchronous reset while SW sits in EX/MEM
        drive(1'b1, SW_OP, 5'd1, 5'd2, 5'd0, 1'b0);
        nop();
        nop();
        chk("sw_mem_write", 32'(memw), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_memw", 32'(memw), 32'd0);
        chk("async_rst_all", 32'(all_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
